// File: rtl/trig_filter_pkg.sv
// Edge-mode encodings shared by the trigger conditioner and its per-channel filter.
// Helper functions decode which pulse polarities a mode enables.
package trig_filter_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic rise_enabled(input edge_mode_e mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic fall_enabled(input edge_mode_e mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/trig_chan_filter.sv
// One trigger channel: synchroniser, glitch filter, edge detect and hold-off gate.
// With TRIG_FILTER_CNT_EN defined, a saturating accepted-pulse counter is added.
module trig_chan_filter
    import trig_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 2,
    parameter int HOLDOFF_W   = 8
`ifdef TRIG_FILTER_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig_in,
    input  edge_mode_e           edge_mode,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 pos_pulse,
    output logic                 neg_pulse,
    output logic                 level
`ifdef TRIG_FILTER_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     evt_cnt
`endif
);

    localparam int GW = $clog2(GLITCH_CYC + 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [GW-1:0]          glitch_cnt_q, glitch_cnt_d;
    logic                   level_q, level_d;
    logic [HOLDOFF_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                   pos_pulse_q, pos_pulse_d;
    logic                   neg_pulse_q, neg_pulse_d;
    logic                   synced;
    logic                   accept;
    logic                   gate_open;
    logic                   issue;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trig_in};
    end

    // A new level is only accepted after GLITCH_CYC consecutive disagreeing samples.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        level_d      = level_q;
        accept       = 1'b0;
        if (synced == level_q) begin
            glitch_cnt_d = '0;
        end else if (glitch_cnt_q == GLITCH_LAST) begin
            accept       = 1'b1;
            level_d      = synced;
            glitch_cnt_d = '0;
        end else begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_comb begin
        gate_open   = (hold_cnt_q == '0);
        pos_pulse_d = accept & synced & gate_open & rise_enabled(edge_mode);
        neg_pulse_d = accept & ~synced & gate_open & fall_enabled(edge_mode);
        issue       = pos_pulse_d | neg_pulse_d;
        hold_cnt_d  = hold_cnt_q;
        if (issue) begin
            hold_cnt_d = holdoff;
        end else if (!gate_open) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            glitch_cnt_q <= '0;
            level_q      <= 1'b0;
            hold_cnt_q   <= '0;
            pos_pulse_q  <= 1'b0;
            neg_pulse_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            glitch_cnt_q <= glitch_cnt_d;
            level_q      <= level_d;
            hold_cnt_q   <= hold_cnt_d;
            pos_pulse_q  <= pos_pulse_d;
            neg_pulse_q  <= neg_pulse_d;
        end
    end

    assign pos_pulse = pos_pulse_q;
    assign neg_pulse = neg_pulse_q;
    assign level     = level_q;

`ifdef TRIG_FILTER_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    // Clear wins over a same-cycle pulse; the count sticks at all-ones.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (cnt_clr) begin
            evt_cnt_d = '0;
        end else if (issue && (evt_cnt_q != '1)) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: rtl/trigger_edge_filter_mc.sv
// Multi-channel trigger conditioner: CH independent trig_chan_filter instances.
// Define TRIG_FILTER_CNT_EN to add cnt_clr/evt_cnt and per-channel saturating event counters.
module trigger_edge_filter_mc
    import trig_filter_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 2,
    parameter int HOLDOFF_W   = 8
`ifdef TRIG_FILTER_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        trigger,
    input  logic [1:0]           edge_mode,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic [CH-1:0]        pos_pulse,
    output logic [CH-1:0]        neg_pulse,
    output logic [CH-1:0]        level
`ifdef TRIG_FILTER_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CH*CNT_W-1:0]  evt_cnt
`endif
);

    edge_mode_e mode;

    assign mode = edge_mode_e'(edge_mode);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        trig_chan_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .GLITCH_CYC  (GLITCH_CYC),
            .HOLDOFF_W   (HOLDOFF_W)
`ifdef TRIG_FILTER_CNT_EN
            ,
            .CNT_W       (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .trig_in   (trigger[i]),
            .edge_mode (mode),
            .holdoff   (holdoff),
            .pos_pulse (pos_pulse[i]),
            .neg_pulse (neg_pulse[i]),
            .level     (level[i])
`ifdef TRIG_FILTER_CNT_EN
            ,
            .cnt_clr   (cnt_clr),
            .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_trigger_edge_filter_mc.sv
// Self-checking bench for trigger_edge_filter_mc against a queue/timestamp reference model.
// Counter checks are included when TRIG_FILTER_CNT_EN is defined.
module tb_trigger_edge_filter_mc;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int GL   = 2;
    localparam int HW   = 8;
`ifdef TRIG_FILTER_CNT_EN
    localparam int CW   = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] trigger = '0;
    logic [1:0]    edge_mode = 2'b00;
    logic [HW-1:0] holdoff = '0;
    logic [CH-1:0] pos_pulse, neg_pulse, level;
`ifdef TRIG_FILTER_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [CH*CW-1:0] evt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: delay queue for the synchroniser, sliding window for the
    // glitch filter, timestamp of the last issued pulse for the hold-off.
    bit            dq[CH][$];
    bit            win[CH][$];
    logic [CH-1:0] m_pos, m_neg, m_lvl;
    bit            has_pulse[CH];
    int            last_pulse[CH];
    int            last_hold[CH];
    int            m_cnt[CH];
    int            edge_no = 0;

    always #5 clk = ~clk;

    trigger_edge_filter_mc #(
        .CH(CH), .SYNC_STAGES(SYNC), .GLITCH_CYC(GL), .HOLDOFF_W(HW)
`ifdef TRIG_FILTER_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .edge_mode(edge_mode),
        .holdoff(holdoff), .pos_pulse(pos_pulse), .neg_pulse(neg_pulse), .level(level)
`ifdef TRIG_FILTER_CNT_EN
        , .cnt_clr(cnt_clr), .evt_cnt(evt_cnt)
`endif
    );

    task automatic model_edge();
        edge_no++;
        for (int c = 0; c < CH; c++) begin
            bit syn;
            bit all_diff;
            bit want;
            bit free;
            if (rst) begin
                dq[c].delete();
                for (int s = 0; s < SYNC; s++) dq[c].push_back(1'b0);
                win[c].delete();
                m_lvl[c] = 1'b0;
                m_pos[c] = 1'b0;
                m_neg[c] = 1'b0;
                has_pulse[c] = 1'b0;
                m_cnt[c] = 0;
            end else begin
                dq[c].push_back(trigger[c]);
                syn = dq[c].pop_front();
                win[c].push_back(syn);
                if (win[c].size() > GL) void'(win[c].pop_front());
                all_diff = (win[c].size() == GL);
                for (int i = 0; i < win[c].size(); i++)
                    if (win[c][i] == m_lvl[c]) all_diff = 1'b0;
                m_pos[c] = 1'b0;
                m_neg[c] = 1'b0;
                if (all_diff) begin
                    m_lvl[c] = ~m_lvl[c];
                    want = m_lvl[c] ? (edge_mode == 2'b01 || edge_mode == 2'b11)
                                    : (edge_mode == 2'b10 || edge_mode == 2'b11);
                    free = !has_pulse[c] || ((edge_no - last_pulse[c]) > last_hold[c]);
                    if (want && free) begin
                        if (m_lvl[c]) m_pos[c] = 1'b1;
                        else          m_neg[c] = 1'b1;
                        has_pulse[c]  = 1'b1;
                        last_pulse[c] = edge_no;
                        last_hold[c]  = int'(holdoff);
                        if (m_cnt[c] < 65535) m_cnt[c]++;
                    end
                end
`ifdef TRIG_FILTER_CNT_EN
                if (cnt_clr) m_cnt[c] = 0;
`endif
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        trigger = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trigger = 4'b1010;
        cycle();
        cycle();
        checks++;
        if ({pos_pulse, neg_pulse, level} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got pos=%b neg=%b lvl=%b want all 0", pos_pulse, neg_pulse, level);
        end
`ifdef TRIG_FILTER_CNT_EN
        checks++;
        if (evt_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_evt_cnt got %h want 0", evt_cnt);
        end
`endif
        rst = 1'b0;
        trigger = '0;
    endtask

    task automatic test_rise_latency();
        int pos_at = -1;
        int pos_n = 0;
        int neg_n = 0;
        do_reset();
        edge_mode = 2'b01;
        holdoff = '0;
        trigger[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL rise_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (pos_pulse[0]) begin
                pos_n++;
                if (pos_at < 0) pos_at = i;
            end
            if (neg_pulse != '0) neg_n++;
        end
        checks++;
        if (pos_at != 4 || pos_n != 1) begin
            errors++;
            $display("[TB] FAIL rise_latency got first=%0d count=%0d want first=4 count=1", pos_at, pos_n);
        end
        checks++;
        if (level[0] !== 1'b1 || neg_n != 0) begin
            errors++;
            $display("[TB] FAIL rise_level got lvl0=%b negs=%0d want 1 and 0", level[0], neg_n);
        end
    endtask

    task automatic test_glitch();
        int pulses_a = 0;
        int lvl_a = 0;
        int pos_b = 0;
        int neg_b = 0;
        do_reset();
        edge_mode = 2'b11;
        holdoff = '0;
        for (int i = 0; i < 18; i++) begin
            trigger[1] = (i == 0) || (i == 8) || (i == 9);
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL glitch_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (i < 8) begin
                if (pos_pulse[1] | neg_pulse[1]) pulses_a++;
                if (level[1]) lvl_a++;
            end else begin
                if (pos_pulse[1]) pos_b++;
                if (neg_pulse[1]) neg_b++;
            end
        end
        checks++;
        if (pulses_a != 0 || lvl_a != 0) begin
            errors++;
            $display("[TB] FAIL glitch_1cyc got pulses=%0d lvl_high=%0d want 0 and 0", pulses_a, lvl_a);
        end
        checks++;
        if (pos_b != 1 || neg_b != 1) begin
            errors++;
            $display("[TB] FAIL glitch_2cyc got pos=%0d neg=%0d want 1 and 1", pos_b, neg_b);
        end
    endtask

    task automatic test_holdoff();
        int toggles = 0;
        int pos_n = 0;
        int neg_n = 0;
        logic prev_lvl;
        do_reset();
        edge_mode = 2'b11;
        holdoff = 8'd5;
        prev_lvl = level[2];
        for (int i = 0; i < 26; i++) begin
            trigger[2] = (i < 18) ? (((i / 3) % 2) == 0) : 1'b0;
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL holdoff_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (level[2] !== prev_lvl) toggles++;
            prev_lvl = level[2];
            if (pos_pulse[2]) pos_n++;
            if (neg_pulse[2]) neg_n++;
        end
        checks++;
        if (toggles != 6 || pos_n != 3 || neg_n != 0) begin
            errors++;
            $display("[TB] FAIL holdoff_gate got toggles=%0d pos=%0d neg=%0d want 6 3 0", toggles, pos_n, neg_n);
        end
    endtask

    task automatic test_modes();
        int pos_a = 0, neg_a = 0, pul_b = 0, pos_c = 0, neg_c = 0;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            if (i < 10) begin
                edge_mode = 2'b10; holdoff = 8'd0; trigger[3] = (i < 4);
            end else if (i < 18) begin
                edge_mode = 2'b00; holdoff = 8'd10; trigger[3] = (i < 14);
            end else begin
                edge_mode = 2'b11; holdoff = 8'd0; trigger[3] = 1'b1;
            end
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL modes_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (i < 10) begin
                pos_a += int'(pos_pulse[3]); neg_a += int'(neg_pulse[3]);
            end else if (i < 18) begin
                pul_b += int'(pos_pulse[3]) + int'(neg_pulse[3]);
            end else begin
                pos_c += int'(pos_pulse[3]); neg_c += int'(neg_pulse[3]);
            end
        end
        checks++;
        if (pos_a != 0 || neg_a != 1) begin
            errors++;
            $display("[TB] FAIL mode_fall got pos=%0d neg=%0d want 0 1", pos_a, neg_a);
        end
        checks++;
        if (pul_b != 0 || pos_c != 1 || neg_c != 0) begin
            errors++;
            $display("[TB] FAIL mode_off got off_pulses=%0d then pos=%0d neg=%0d want 0 1 0", pul_b, pos_c, neg_c);
        end
    endtask

    task automatic test_simultaneous();
        int all_at = -1;
        int neg_at = -1;
        do_reset();
        edge_mode = 2'b01;
        holdoff = '0;
        trigger = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL simul_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (pos_pulse == 4'hF && all_at < 0) all_at = i;
        end
        checks++;
        if (all_at != 4) begin
            errors++;
            $display("[TB] FAIL simul_rise got all-four cycle=%0d want 4", all_at);
        end
`ifdef TRIG_FILTER_CNT_EN
        checks++;
        if (evt_cnt !== {4{16'd1}}) begin
            errors++;
            $display("[TB] FAIL simul_count got %h want 0001 each", evt_cnt);
        end
`endif
        edge_mode = 2'b11;
        trigger = 4'h0;
        for (int i = 1; i <= 6; i++) begin
`ifdef TRIG_FILTER_CNT_EN
            cnt_clr = (i == 4);
`endif
            cycle();
            if (neg_pulse == 4'hF && neg_at < 0) neg_at = i;
        end
`ifdef TRIG_FILTER_CNT_EN
        cnt_clr = 1'b0;
        checks++;
        if (evt_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL clr_priority got %h want 0", evt_cnt);
        end
`endif
        checks++;
        if (neg_at != 4) begin
            errors++;
            $display("[TB] FAIL simul_fall got all-four cycle=%0d want 4", neg_at);
        end
    endtask

    task automatic test_reset_release();
        int pos_at = -1;
        edge_mode = 2'b01;
        holdoff = '0;
        trigger = '0;
        trigger[0] = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL release_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
            if (pos_pulse[0] && pos_at < 0) pos_at = i;
        end
        checks++;
        if (pos_at != 4) begin
            errors++;
            $display("[TB] FAIL release_rise got pulse cycle=%0d want 4", pos_at);
        end
    endtask

    task automatic test_rst_mid_holdoff();
        int pos_at = -1;
        do_reset();
        edge_mode = 2'b11;
        holdoff = 8'd200;
        trigger[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) trigger[0] = 1'b0;
            cycle();
        end
        trigger[0] = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({pos_pulse, neg_pulse, level} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got %b/%b/%b want all 0", pos_pulse, neg_pulse, level);
        end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (pos_pulse[0] && pos_at < 0) pos_at = i;
        end
        checks++;
        if (pos_at != 4) begin
            errors++;
            $display("[TB] FAIL midrst_holdoff got pulse cycle=%0d want 4", pos_at);
        end
    endtask

    task automatic test_random();
`ifdef TRIG_FILTER_CNT_EN
        logic [CH*CW-1:0] exp_cnt;
`endif
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i % 50 == 0) edge_mode = 2'($urandom_range(3));
            if (i % 20 == 0) holdoff = HW'($urandom_range(6));
            for (int c = 0; c < CH; c++)
                if ($urandom_range(3) == 0) trigger[c] = ~trigger[c];
            rst = ($urandom_range(149) == 0);
`ifdef TRIG_FILTER_CNT_EN
            cnt_clr = ($urandom_range(39) == 0);
`endif
            cycle();
            checks++;
            if ({pos_pulse, neg_pulse, level} !== {m_pos, m_neg, m_lvl}) begin
                errors++;
                $display("[TB] FAIL random_model cyc=%0d got %b/%b/%b want %b/%b/%b", i, pos_pulse, neg_pulse, level, m_pos, m_neg, m_lvl);
            end
`ifdef TRIG_FILTER_CNT_EN
            for (int c = 0; c < CH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
            checks++;
            if (evt_cnt !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL random_count cyc=%0d got %h want %h", i, evt_cnt, exp_cnt);
            end
`endif
        end
        rst = 1'b0;
`ifdef TRIG_FILTER_CNT_EN
        cnt_clr = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_holdoff();
        test_modes();
        test_simultaneous();
        test_reset_release();
        test_rst_mid_holdoff();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_edge_filter_mc.md
# trigger_edge_filter_mc

Multi-channel trigger conditioner and edge detector for the TDC front end. Each channel synchronises an asynchronous trigger, rejects glitches shorter than a programmable number of cycles, and emits single-cycle rising/falling pulses under a selectable edge mode. A programmable per-channel hold-off dead time suppresses retriggering. Outputs feed the coarse-counter capture and fine-TDC start/stop logic.

## Interface
- CH, 4: number of independent trigger channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- GLITCH_CYC, 2: consecutive cycles a new level must persist before acceptance (≥1)
- HOLDOFF_W, 8: width of hold-off value/counter
- CNT_W, 16: event counter width (only with TRIG_FILTER_CNT_EN)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trigger  in  CH  asynchronous trigger inputs
- edge_mode  in  2  00 off, 01 rising, 10 falling, 11 both; shared by all channels
- holdoff  in  HOLDOFF_W  dead-time cycles after an accepted pulse
- pos_pulse  out  CH  registered one-cycle rising-edge pulse per channel
- neg_pulse  out  CH  registered one-cycle falling-edge pulse per channel
- level  out  CH  filtered (debounced) trigger level
- cnt_clr  in  1  clear all event counters (TRIG_FILTER_CNT_EN only)
- evt_cnt  out  CH*CNT_W  accepted-pulse counts, channel 0 in LSBs (TRIG_FILTER_CNT_EN only)

## Operation
- Per channel: sync chain → glitch filter → edge detect → hold-off gate → pulse registers.
- Glitch filter: counter clears whenever synced input equals `level`; increments while it differs; when it reaches GLITCH_CYC, `level` takes the synced value and counter clears. Pulses shorter than GLITCH_CYC cycles never change `level`.
- Edge: `level` 0→1 is rising, 1→0 falling. Pulse issued only if mode enables that polarity and hold-off counter is 0.
- Hold-off: on any issued pulse, counter loads `holdoff` (sampled that cycle); decrements by 1 per cycle to 0. Edges while non-zero: `level` still updates, pulse suppressed, not counted. holdoff=0 → no dead time.
- edge_mode=00: no pulses, no hold-off loads; `level` still tracks.
- edge_mode and holdoff are used combinationally each cycle; changes apply to the next edge decision.
- Counters (if enabled): +1 per issued pulse (either polarity), saturate at all-ones; cnt_clr has priority over increment in the same cycle.
- Channels fully independent; simultaneous edges on several channels all issue pulses.

## Timing
- Reset: sync chain, `level`, glitch/hold-off counters, pos_pulse, neg_pulse, evt_cnt all 0.
- Latency: input change first sampled at edge E0; pulse and `level` change are visible after edge E0+SYNC_STAGES+GLITCH_CYC−1 (defaults: 3 edges after E0), high for exactly one cycle.
- pos_pulse and neg_pulse of one channel are never high in the same cycle.
- Minimum spacing of issued pulses on a channel: max(GLITCH_CYC, holdoff+1) cycles.
- Trigger held high through reset release: treated as a rising edge (level resets to 0), pulse issued after full latency.
- rst asserted mid-operation: outputs 0 in the cycle after the rst edge; pending hold-off and partial glitch counts discarded.

## Configuration
- TRIG_FILTER_CNT_EN defined: cnt_clr and evt_cnt ports plus per-channel saturating counters present.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package trig_filter_pkg: edge_mode encodings (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the 2-bit edge_mode typedef.
- Sub-module trig_chan_filter: one channel (sync, glitch filter, edge detect, hold-off, optional counter), instantiated CH times in a generate loop.

## Test plan
- Reset, trigger[0] 0→1 held, mode 01, holdoff 0 → single pos_pulse[0] 3 edges after first sampling edge; level[0]=1; no neg_pulse.
- 1-cycle high glitch on trigger[1] (GLITCH_CYC=2) → no pulse, level[1] stays 0; 2-cycle high → pos then neg pulse.
- Mode 11, holdoff 5, toggles every 3 cycles → pulse, next edge suppressed, subsequent edge accepted; level tracks all toggles.
- Mode 10 then 00 → only neg_pulse; with 00 no pulses and no hold-off loads.
- All 4 channels rise together → four pos_pulse bits in the same cycle; evt_cnt each 1; cnt_clr with a concurrent pulse → counter 0.
- Trigger high across reset release → one pos_pulse after latency; rst mid hold-off → hold-off cleared, next edge pulses.
